// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundles the display-load strobe and the scanned segment/anode
// outputs of seg7_scan_driver.
//
// Handshake: load is a single-cycle strobe with no back-pressure. Whenever
// load is high on a clock edge the driver captures digits_in/dp_in; there is
// no ready signal because the driver can accept a load in every cycle.
// seg/an/frame_done are registered outputs from the driver.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [7:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, digits_in, dp_in,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, digits_in, dp_in,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed NUM_DIGITS x 7-segment scan driver with a
// latched shadow register, SCAN_DIV prescaler and a one-cycle blank between
// digits to stop ghosting. frame_done pulses on the blank cycle after the
// last digit.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros on
// every digit except digit 0 (dp still shown).
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic           clk,
  input  logic           rst,
  seg7_scan_if.slave     bus,
  output logic           dbg_state_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [7:0]                  seg_q, seg_d;
  logic                        fd_q, fd_d;
  logic [NUM_DIGITS-1:0][3:0]  dig_q;
  logic [NUM_DIGITS-1:0]       dp_q;
  logic                        blank_cur;
  logic [7:0]                  shown_seg;

  // Active-high segment pattern {g..a}; values above 9 show a dash unless hex.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    r = 7'h40;
    case (v)
      4'd0:  r = 7'h3F;
      4'd1:  r = 7'h06;
      4'd2:  r = 7'h5B;
      4'd3:  r = 7'h4F;
      4'd4:  r = 7'h66;
      4'd5:  r = 7'h6D;
      4'd6:  r = 7'h7D;
      4'd7:  r = 7'h07;
      4'd8:  r = 7'h7F;
      4'd9:  r = 7'h6F;
      4'd10: r = (HEX_MODE != 0) ? 7'h77 : 7'h40;
      4'd11: r = (HEX_MODE != 0) ? 7'h7C : 7'h40;
      4'd12: r = (HEX_MODE != 0) ? 7'h39 : 7'h40;
      4'd13: r = (HEX_MODE != 0) ? 7'h5E : 7'h40;
      4'd14: r = (HEX_MODE != 0) ? 7'h79 : 7'h40;
      4'd15: r = (HEX_MODE != 0) ? 7'h71 : 7'h40;
      default: r = 7'h40;
    endcase
    return r;
  endfunction

  // Shadow register: captures the display contents on a load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= '0;
      dp_q  <= '0;
    end else if (bus.load) begin
      dig_q <= bus.digits_in;
      dp_q  <= bus.dp_in;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // lz[k]: digit k and every higher-order digit are zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (dig_q[NUM_DIGITS-1] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz[k] = (dig_q[k] == 4'd0) && lz[k+1];
    end
  end

  assign blank_cur = (idx_q != '0) && lz[idx_q];
`else
  assign blank_cur = 1'b0;
`endif

  assign shown_seg = {dp_q[idx_q], blank_cur ? 7'h00 : decode(dig_q[idx_q])};

  // Scan FSM next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    an_d    = '0;
    seg_d   = 8'h00;
    fd_d    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
        an_d    = NUM_DIGITS'(1) << idx_q;
        seg_d   = shown_seg;
      end
      ST_SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_BLANK;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          fd_d    = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          an_d  = NUM_DIGITS'(1) << idx_q;
          seg_d = shown_seg;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // State and output registers; polarity is applied as the outputs register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= AN_POL;
      seg_q   <= SEG_POL;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d ^ AN_POL;
      seg_q   <= seg_d ^ SEG_POL;
      fd_q    <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances (default, HEX_MODE=1,
// SEG_ACTIVE_LOW=1) share the same stimulus; expectations come from a
// frame-position model of the scan and a shadow copy of the loaded digits.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int SLOT  = SD + 1;
  localparam int FRAME = ND * SLOT;
  localparam int W     = 1 + ND + 8 + 1;

  localparam logic [6:0] DEC_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND)) if_main ();
  seg7_scan_if #(.NUM_DIGITS(ND)) if_hex ();
  seg7_scan_if #(.NUM_DIGITS(ND)) if_al ();

  logic st_main, st_hex, st_al;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(0), .SEG_ACTIVE_LOW(0)) dut_main (
    .clk(clk), .rst(rst), .bus(if_main.slave), .dbg_state_o(st_main));
  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(1), .SEG_ACTIVE_LOW(0)) dut_hex (
    .clk(clk), .rst(rst), .bus(if_hex.slave), .dbg_state_o(st_hex));
  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(0), .SEG_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .bus(if_al.slave), .dbg_state_o(st_al));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hex_q[$];
  logic [W-1:0] exp_al_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Model state: edges since the last reset edge, and the shadow contents.
  int            t = 0;
  logic [3:0]    sh_dig [ND];
  logic [ND-1:0] sh_dp = '0;

  function automatic logic [7:0] model_seg(input int k, input bit hex);
    logic [3:0] v;
    logic [6:0] s;
    v = sh_dig[k];
    if (v > 4'd9 && !hex) s = 7'h40;
    else                  s = DEC_TAB[v];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      bit allz;
      allz = 1'b1;
      for (int j = k; j < ND; j++) if (sh_dig[j] != 4'd0) allz = 1'b0;
      if (k > 0 && allz) s = 7'h00;
    end
`endif
    return {sh_dp[k], s};
  endfunction

  task automatic compare(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] dp);
    logic [ND-1:0] an_e;
    logic [7:0]    seg_e, seg_h;
    logic          fd_e, st_e;
    int            p;
    rst = r;
    if_main.load = ld; if_main.digits_in = d; if_main.dp_in = dp;
    if_hex.load  = ld; if_hex.digits_in  = d; if_hex.dp_in  = dp;
    if_al.load   = ld; if_al.digits_in   = d; if_al.dp_in   = dp;
    an_e = '0; seg_e = 8'h00; seg_h = 8'h00; fd_e = 1'b0; st_e = 1'b0;
    if (r) begin
      t = 0;
    end else begin
      t++;
      p = (t - 1) % FRAME;
      if ((p % SLOT) < SD) begin
        st_e  = 1'b1;
        an_e  = ND'(1 << (p / SLOT));
        seg_e = model_seg(p / SLOT, 1'b0);
        seg_h = model_seg(p / SLOT, 1'b1);
      end
      fd_e = (p == FRAME - 1);
    end
    exp_q.push_back({st_e, an_e, seg_e, fd_e});
    exp_hex_q.push_back({st_e, an_e, seg_h, fd_e});
    exp_al_q.push_back({st_e, ~an_e, ~seg_e, fd_e});
    if (r) begin
      for (int k = 0; k < ND; k++) sh_dig[k] = 4'd0;
      sh_dp = '0;
    end else if (ld) begin
      for (int k = 0; k < ND; k++) sh_dig[k] = d[4*k +: 4];
      sh_dp = dp;
    end
    @(posedge clk);
    #1;
    compare("main", {st_main, if_main.an, if_main.seg, if_main.frame_done}, exp_q.pop_front());
    compare("hex",  {st_hex,  if_hex.an,  if_hex.seg,  if_hex.frame_done},  exp_hex_q.pop_front());
    compare("alow", {st_al,   if_al.an,   if_al.seg,   if_al.frame_done},   exp_al_q.pop_front());
  endtask

  // Idle cycles with random data on the inputs; load stays low so it is ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    drive(1'b0, 1'b1, d, dp);
  endtask

  // Advance until the model is at frame position pos (bounded to one frame).
  task automatic seek(input int pos);
    for (int i = 0; i < FRAME && ((t - 1) % FRAME) != pos; i++) idle(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < ND; k++) sh_dig[k] = 4'd0;
    drive(1'b1, 1'b0, 16'h0000, 4'b0000);
    drive(1'b1, 1'b1, 16'hFFFF, 4'b1111);
    idle(2 * FRAME);

    load(16'h9520, 4'b0100);
    idle(FRAME + 4);

    load(16'h00A3, 4'b0000);
    idle(FRAME + 4);

    // Reset while digit 2 is lit with cnt=2.
    seek(2 * SLOT + 2);
    drive(1'b1, 1'b0, 16'h0000, 4'b0000);
    idle(6);

    load(16'h0008, 4'b0000);
    idle(FRAME + 2);

    load(16'h0040, 4'b0000);
    idle(FRAME + 2);

    load(16'h0000, 4'b0000);
    idle(FRAME + 2);

    // Load on the edge that moves SHOW -> BLANK.
    load(16'hBEEF, 4'b0001);
    idle(3);
    seek(SD - 1);
    load(16'h1234, 4'b1010);
    idle(FRAME + 4);

    for (int i = 0; i < 5; i++) begin
      load(16'($urandom), 4'($urandom));
      idle($urandom_range(3, 25));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
